// File: rtl/ps2mouse_init_seq.sv
// ---------------------------------------------------------------------------
// ps2mouse_init_seq
//
// Host-side PS/2 mouse initialisation sequencer. Walks a command table through
// a byte-level PS/2 transceiver, checks every response byte, resends once on
// FE, restarts the whole sequence on any error or timeout, and gives up after
// c_max_retries full restarts. On success it raises stream_en so the packet
// decoder owns the rx byte stream, and reports the mouse ID / wheel format.
//
// Build option:
//   PS2MOUSE_WHEEL_DETECT_EN  defined   -> full table (reset, F3 C8/64/50
//                                          knock sequence, F2, F4); wheel is
//                                          derived from the ID byte.
//                             undefined -> FF, F2, F4 only; wheel tied to 0.
//
// Ports:
//   clk, reset_n          25 MHz clock, async active-low reset
//   restart               one-cycle pulse, restarts from any state
//   tx_data/tx_req        command byte + one-cycle send request
//   tx_busy/tx_done/tx_err transceiver status
//   rx_data/rx_valid      received byte strobe
//   stream_en             initialisation complete
//   init_error            retries exhausted
//   mouse_id, wheel       ID returned for F2; 4-byte packet format flag
//   retry_cnt, step       full-sequence retries used; current table index
// ---------------------------------------------------------------------------
module ps2mouse_init_seq #(
    parameter int unsigned c_startup_cycles = 12500000,
    parameter int unsigned c_timeout_cycles = 2500000,
    parameter int unsigned c_max_retries    = 3
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       restart,
    output logic [7:0] tx_data,
    output logic       tx_req,
    input  logic       tx_busy,
    input  logic       tx_done,
    input  logic       tx_err,
    input  logic [7:0] rx_data,
    input  logic       rx_valid,
    output logic       stream_en,
    output logic       init_error,
    output logic [7:0] mouse_id,
    output logic       wheel,
    output logic [1:0] retry_cnt,
    output logic [3:0] step
);

    localparam int unsigned SW = (c_startup_cycles > 0) ? $clog2(c_startup_cycles + 1) : 1;
    localparam int unsigned TW = $clog2(c_timeout_cycles + 1);

`ifdef PS2MOUSE_WHEEL_DETECT_EN
    localparam logic WHEEL_EN = 1'b1;
`else
    localparam logic WHEEL_EN = 1'b0;
`endif

    localparam logic [3:0] STEP_RESET  = 4'd0;
    localparam logic [3:0] STEP_GET_ID = 4'd7;
    localparam logic [3:0] STEP_LAST   = 4'd8;
    localparam logic [2:0] BAT_WINDOWS = 3'd5;

    typedef enum logic [3:0] {
        S_STARTUP,
        S_SEND,
        S_WAIT_TX,
        S_WAIT_ACK,
        S_WAIT_BAT,
        S_WAIT_BATID,
        S_WAIT_ID,
        S_RETRY,
        S_DONE,
        S_FAIL
    } state_e;

    state_e        state_q;
    logic [SW-1:0] st_cnt_q;
    logic [TW-1:0] to_q;
    logic [2:0]    bat_q;     // timeout windows spent waiting for BAT (AA)
    logic          fe_q;      // an FE has already been seen for this step
    logic [7:0]    tx_data_q;
    logic          tx_req_q;
    logic          stream_en_q;
    logic          init_error_q;
    logic [7:0]    mouse_id_q;
    logic          wheel_q;
    logic [1:0]    retry_q;
    logic [3:0]    step_q;

    logic to_hit;
    assign to_hit = (to_q == TW'(c_timeout_cycles));

    function automatic logic [7:0] cmd_byte(input logic [3:0] s);
        case (s)
            4'd0:    return 8'hFF;
            4'd1:    return 8'hF3;
            4'd2:    return 8'hC8;
            4'd3:    return 8'hF3;
            4'd4:    return 8'h64;
            4'd5:    return 8'hF3;
            4'd6:    return 8'h50;
            4'd7:    return 8'hF2;
            4'd8:    return 8'hF4;
            default: return 8'h00;
        endcase
    endfunction

    // Without wheel detection the knock sequence (steps 1-6) is jumped over.
    function automatic logic [3:0] next_step(input logic [3:0] s);
`ifdef PS2MOUSE_WHEEL_DETECT_EN
        return s + 4'd1;
`else
        return (s == STEP_RESET) ? STEP_GET_ID : s + 4'd1;
`endif
    endfunction

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= S_STARTUP;
            st_cnt_q     <= '0;
            to_q         <= '0;
            bat_q        <= '0;
            fe_q         <= 1'b0;
            tx_data_q    <= '0;
            tx_req_q     <= 1'b0;
            stream_en_q  <= 1'b0;
            init_error_q <= 1'b0;
            mouse_id_q   <= '0;
            wheel_q      <= 1'b0;
            retry_q      <= '0;
            step_q       <= '0;
        end else begin
            tx_req_q <= 1'b0;
            // Free-running saturating timeout; states clear it when a new
            // response window starts.
            if (!to_hit) to_q <= to_q + TW'(1);

            if (restart) begin
                state_q      <= S_STARTUP;
                st_cnt_q     <= '0;
                to_q         <= '0;
                bat_q        <= '0;
                fe_q         <= 1'b0;
                tx_data_q    <= '0;
                stream_en_q  <= 1'b0;
                init_error_q <= 1'b0;
                mouse_id_q   <= '0;
                wheel_q      <= 1'b0;
                retry_q      <= '0;
                step_q       <= '0;
            end else begin
                case (state_q)
                    S_STARTUP: begin
                        if (st_cnt_q >= SW'(c_startup_cycles)) begin
                            step_q  <= STEP_RESET;
                            fe_q    <= 1'b0;
                            state_q <= S_SEND;
                        end else begin
                            st_cnt_q <= st_cnt_q + SW'(1);
                        end
                    end
                    S_SEND: begin
                        if (!tx_busy) begin
                            tx_req_q  <= 1'b1;
                            tx_data_q <= cmd_byte(step_q);
                            state_q   <= S_WAIT_TX;
                        end
                    end
                    S_WAIT_TX: begin
                        if (tx_done) begin
                            to_q    <= '0;
                            state_q <= S_WAIT_ACK;
                        end else if (tx_err) begin
                            state_q <= S_RETRY;
                        end
                    end
                    S_WAIT_ACK: begin
                        if (rx_valid) begin
                            if (rx_data == 8'hFA) begin
                                to_q <= '0;
                                if (step_q == STEP_RESET) begin
                                    bat_q   <= '0;
                                    state_q <= S_WAIT_BAT;
                                end else if (step_q == STEP_GET_ID) begin
                                    state_q <= S_WAIT_ID;
                                end else if (step_q == STEP_LAST) begin
                                    stream_en_q <= 1'b1;
                                    wheel_q     <= WHEEL_EN & (mouse_id_q == 8'h03);
                                    state_q     <= S_DONE;
                                end else begin
                                    step_q  <= next_step(step_q);
                                    fe_q    <= 1'b0;
                                    state_q <= S_SEND;
                                end
                            end else if (rx_data == 8'hFE && !fe_q) begin
                                fe_q    <= 1'b1;
                                state_q <= S_SEND;
                            end else begin
                                state_q <= S_RETRY;
                            end
                        end else if (to_hit) begin
                            state_q <= S_RETRY;
                        end
                    end
                    S_WAIT_BAT: begin
                        // Self-test can take 500 ms, so several windows are allowed.
                        if (rx_valid) begin
                            if (rx_data == 8'hAA) begin
                                to_q    <= '0;
                                state_q <= S_WAIT_BATID;
                            end else begin
                                state_q <= S_RETRY;
                            end
                        end else if (to_hit) begin
                            if (bat_q == BAT_WINDOWS - 3'd1) begin
                                state_q <= S_RETRY;
                            end else begin
                                bat_q <= bat_q + 3'd1;
                                to_q  <= '0;
                            end
                        end
                    end
                    S_WAIT_BATID: begin
                        if (rx_valid) begin
                            if (rx_data == 8'h00) begin
                                step_q  <= next_step(step_q);
                                fe_q    <= 1'b0;
                                state_q <= S_SEND;
                            end else begin
                                state_q <= S_RETRY;
                            end
                        end else if (to_hit) begin
                            state_q <= S_RETRY;
                        end
                    end
                    S_WAIT_ID: begin
                        if (rx_valid) begin
                            mouse_id_q <= rx_data;
                            step_q     <= next_step(step_q);
                            fe_q       <= 1'b0;
                            state_q    <= S_SEND;
                        end else if (to_hit) begin
                            state_q <= S_RETRY;
                        end
                    end
                    S_RETRY: begin
                        if (retry_q == 2'(c_max_retries)) begin
                            init_error_q <= 1'b1;
                            stream_en_q  <= 1'b0;
                            state_q      <= S_FAIL;
                        end else begin
                            retry_q <= retry_q + 2'd1;
                            step_q  <= STEP_RESET;
                            fe_q    <= 1'b0;
                            state_q <= S_SEND;
                        end
                    end
                    S_DONE: ;  // decoder owns rx from here on
                    S_FAIL: ;  // held until restart or reset
                    default: state_q <= S_STARTUP;
                endcase
            end
        end
    end

    assign tx_data    = tx_data_q;
    assign tx_req     = tx_req_q;
    assign stream_en  = stream_en_q;
    assign init_error = init_error_q;
    assign mouse_id   = mouse_id_q;
    assign wheel      = wheel_q;
    assign retry_cnt  = retry_q;
    assign step       = step_q;

endmodule
